piece_generator: RTL and testbench

Seven-bag tetromino randomizer feeding the spawn path of `game_control`. It keeps one drawn piece staged on its output, with a valid flag. A single-cycle `req` pulse consumes the staged piece and starts the draw of the next one. Every aligned group of 7 draws contains each of I, J, L, O, S, T, Z exactly once. Encoding is the shared `TETROMINO_*` index: I=0, J=1, L=2, O=3, S=4, T=5, Z=6, EMPTY=7.

---
 rtl/piece_generator_pkg.sv | 37 +++
 rtl/lfsr16.sv | 34 +++
 rtl/piece_generator.sv | 96 +++++++++
 tb/tb_piece_generator.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/piece_generator_pkg.sv
// Shared tetromino encoding and generator state type for the spawn path.
// Imported by the piece generator and its LFSR.
package piece_generator_pkg;

  localparam int unsigned TetrominoW = 3;
  localparam int unsigned NumPieces  = 7;

  typedef logic [TetrominoW-1:0] tetromino_t;

  localparam tetromino_t TETROMINO_I     = 3'd0;
  localparam tetromino_t TETROMINO_J     = 3'd1;
  localparam tetromino_t TETROMINO_L     = 3'd2;
  localparam tetromino_t TETROMINO_O     = 3'd3;
  localparam tetromino_t TETROMINO_S     = 3'd4;
  localparam tetromino_t TETROMINO_T     = 3'd5;
  localparam tetromino_t TETROMINO_Z     = 3'd6;
  localparam tetromino_t TETROMINO_EMPTY = 3'd7;

  localparam logic [NumPieces-1:0] BagFull = 7'h7F;

  typedef enum logic [1:0] {
    StStart,
    StProbe,
    StReady
  } gen_state_e;

  // Map a raw 3-bit value onto a valid piece index (EMPTY folds to I).
  function automatic tetromino_t fold_idx(input logic [2:0] raw);
    return (raw == TETROMINO_EMPTY) ? TETROMINO_I : tetromino_t'(raw);
  endfunction

  // Next probe position, wrapping Z back to I.
  function automatic tetromino_t wrap_next(input tetromino_t cur);
    return (cur == TETROMINO_Z) ? TETROMINO_I : tetromino_t'(cur + 3'd1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), shifting right when enabled.
// A zero seed is replaced by 1 so the register can never lock up.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  localparam logic [15:0] Mask     = 16'hB400;
  localparam logic [15:0] ResetVal = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? Mask : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= ResetVal;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/piece_generator.sv
// Seven-bag tetromino randomizer: stages one drawn piece with a valid flag;
// a req in READY consumes it and launches the next draw.
module piece_generator
  import piece_generator_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  output logic [TetrominoW-1:0] next_idx,
  output logic                  next_valid,
  output logic [2:0]            bag_count
);

  logic [15:0]          lfsr;
  gen_state_e           state_q, state_d;
  tetromino_t           probe_q, probe_d;
  logic [NumPieces-1:0] used_q, used_d, used_set;
  logic [2:0]           bag_q, bag_d;
  tetromino_t           idx_q, idx_d;
  logic                 valid_q, valid_d;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk(clk),
    .rst(rst),
    .en (1'b1),
    .q  (lfsr)
  );

  always_comb begin
    state_d  = state_q;
    probe_d  = probe_q;
    used_d   = used_q;
    used_set = used_q;
    bag_d    = bag_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    case (state_q)
      StStart: begin
        probe_d = fold_idx(lfsr[2:0]);
        state_d = StProbe;
      end
      StProbe: begin
        if (!used_q[probe_q]) begin
          idx_d    = probe_q;
          valid_d  = 1'b1;
          used_set = used_q | (7'b000_0001 << probe_q);
          // Completing the bag clears it on the same edge as the commit.
          if (used_set == BagFull) begin
            used_d = '0;
            bag_d  = 3'd0;
          end else begin
            used_d = used_set;
            bag_d  = bag_q + 3'd1;
          end
          state_d = StReady;
        end else begin
          probe_d = wrap_next(probe_q);
        end
      end
      StReady: begin
        if (req) begin
          valid_d = 1'b0;
          state_d = StStart;
        end
      end
      default: state_d = StStart;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StStart;
      probe_q <= TETROMINO_I;
      used_q  <= '0;
      bag_q   <= 3'd0;
      idx_q   <= TETROMINO_EMPTY;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      probe_q <= probe_d;
      used_q  <= used_d;
      bag_q   <= bag_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign next_idx   = idx_q;
  assign next_valid = valid_q;
  assign bag_count  = bag_q;

endmodule

// File: tb/tb_piece_generator.sv
// Directed bench for piece_generator: reset, bag permutations, latency,
// overrun, mid-draw reset, zero seed and twin-instance determinism.
module tb_piece_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       req_z = 1'b0;
  logic [2:0] next_idx, idx_b, idx_z;
  logic       next_valid, valid_b, valid_z;
  logic [2:0] bag_count, bag_b, bag_z;

  int checks = 0;
  int passes = 0;
  int commits = 0;
  int seq[14];

  always #5 clk = ~clk;

  piece_generator #(.SEED(16'hACE1)) u_dut (
    .clk(clk), .rst(rst), .req(req),
    .next_idx(next_idx), .next_valid(next_valid), .bag_count(bag_count)
  );

  piece_generator #(.SEED(16'hACE1)) u_twin (
    .clk(clk), .rst(rst), .req(req),
    .next_idx(idx_b), .next_valid(valid_b), .bag_count(bag_b)
  );

  piece_generator #(.SEED(16'h0000)) u_zero (
    .clk(clk), .rst(rst), .req(req_z),
    .next_idx(idx_z), .next_valid(valid_z), .bag_count(bag_z)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (next_valid !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check(tag, 16'(next_valid), 16'd1);
  endtask

  // Consume the staged piece at this negedge and wait for the next commit.
  task automatic consume(output int idx, output int lat);
    check("valid_before_req", 16'(next_valid), 16'd1);
    check("twin_idx", 16'(idx_b), 16'(next_idx));
    idx = int'(next_idx);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("valid_drop", 16'(next_valid), 16'd0);
    lat = 0;
    while (next_valid !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    assert (lat >= 2 && lat <= 8) passes++;
    else $error("FAIL latency: observed %0d expected 2..8", lat);
    commits++;
    check("bag_count", 16'(bag_count), 16'(commits % 7));
  endtask

  task automatic check_perm(input string tag, input int base);
    logic [6:0] mask = '0;
    for (int i = 0; i < 7; i++) begin
      if (seq[base+i] < 7) mask = mask | (7'b1 << seq[base+i]);
    end
    check(tag, 16'(mask), 16'h007F);
  endtask

  task automatic check_prefix(input string tag);
    check({tag, "_d1"}, 16'(seq[0]), 16'd1);
    check({tag, "_d2"}, 16'(seq[1]), 16'd4);
    check({tag, "_d3"}, 16'(seq[2]), 16'd3);
    check({tag, "_d4"}, 16'(seq[3]), 16'd2);
  endtask

  initial begin
    int d, lat, rises;
    logic prev;
    logic [6:0] zmask;
    logic [2:0] bag_before;

    // Reset held for 5 cycles.
    repeat (5) @(negedge clk);
    check("rst_idx", 16'(next_idx), 16'd7);
    check("rst_valid", 16'(next_valid), 16'd0);
    check("rst_bag", 16'(bag_count), 16'd0);
    rst = 1'b0;
    wait_valid("first_valid");
    check("first_idx_range", 16'(next_idx < 3'd7), 16'd1);
    commits = 1;
    check("first_bag", 16'(bag_count), 16'd1);

    // Two full bags; first draws hand-derived from the LFSR stream.
    for (int i = 0; i < 14; i++) begin
      consume(d, lat);
      seq[i] = d;
    end
    check_prefix("seq");
    check_perm("bag1_perm", 0);
    check_perm("bag2_perm", 7);

    // Latency sweep (also extends twin comparison past 100 draws).
    for (int i = 0; i < 90; i++) consume(d, lat);

    // Overrun: req held into the START cycle is ignored.
    check("ovr_valid", 16'(next_valid), 16'd1);
    bag_before = bag_count;
    req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req = 1'b0;
    wait_valid("ovr_recover");
    commits++;
    check("ovr_bag_step", 16'(bag_count), 16'((bag_before + 1) % 7));
    repeat (3) @(negedge clk);
    check("ovr_valid_held", 16'(next_valid), 16'd1);
    check("ovr_bag_held", 16'(bag_count), 16'(commits % 7));

    // req held high for 20 cycles: one piece per valid rise.
    rises = 0;
    prev = 1'b1;
    req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (prev) begin
        check("hold_consume", 16'(next_valid), 16'd0);
      end else if (next_valid) begin
        rises++;
        commits++;
        check("hold_bag", 16'(bag_count), 16'(commits % 7));
      end
      prev = next_valid;
    end
    req = 1'b0;
    if (!next_valid) begin
      wait_valid("hold_tail");
      commits++;
      check("hold_tail_bag", 16'(bag_count), 16'(commits % 7));
    end
    checks++;
    assert (rises >= 2) passes++;
    else $error("FAIL hold_rises: observed %0d expected >=2", rises);

    // Mid-draw reset during PROBE after three draws.
    consume(d, lat);
    consume(d, lat);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_idx", 16'(next_idx), 16'd7);
    check("mid_rst_valid", 16'(next_valid), 16'd0);
    check("mid_rst_bag", 16'(bag_count), 16'd0);
    rst = 1'b0;
    commits = 0;
    wait_valid("mid_first_valid");
    commits = 1;
    check("mid_first_bag", 16'(bag_count), 16'd1);
    for (int i = 0; i < 7; i++) begin
      consume(d, lat);
      seq[i] = d;
    end
    check_prefix("mid_seq");
    check_perm("mid_perm", 0);

    // Zero seed: guarded to 1, so the first draw is J.
    zmask = '0;
    for (int i = 0; i < 7; i++) begin
      int n = 0;
      while (valid_z !== 1'b1 && n < 12) begin
        @(negedge clk);
        n++;
      end
      check("zero_valid", 16'(valid_z), 16'd1);
      if (i == 0) check("zero_first", 16'(idx_z), 16'd1);
      if (idx_z < 3'd7) zmask = zmask | (7'b1 << idx_z);
      req_z = 1'b1;
      @(negedge clk);
      req_z = 1'b0;
    end
    check("zero_perm", 16'(zmask), 16'h007F);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
